cpu_axi_arbiter: RTL and testbench
==================================

# cpu_axi_arbiter

Single-outstanding arbiter and bridge that shares one AXI master port between the instruction-fetch and data-memory SRAM-like request interfaces of the mips-AXI core. It sits between the fetch/memory stages and the external bus. The pipeline derives `i_stall` and `d_stall` for the hazard unit from this block's `*_data_ok` handshakes. It serialises all traffic so that exactly one AXI transaction is in flight at any time.

## Interface
- Parameters: none; address and data are fixed at 32 bits.
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- inst_req  in  1  fetch read request; held until `inst_addr_ok`
- inst_addr  in  32  fetch byte address, word-aligned
- inst_addr_ok  out  1  fetch request accepted (combinational, IDLE only)
- inst_rdata  out  32  fetch read data; valid with `inst_data_ok`
- inst_data_ok  out  1  one-cycle pulse, fetch complete
- data_req  in  1  load/store request; held until `data_addr_ok`
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 byte, 1 half, 2 word; 3 treated as word
- data_addr  in  32  load/store byte address
- data_wdata  in  32  store data, already lane-aligned
- data_addr_ok  out  1  data request accepted (combinational, IDLE only)
- data_rdata  out  32  load data; valid with `data_data_ok`
- data_data_ok  out  1  one-cycle pulse, load or store complete
- axaddr  out  32  latched address, shared by AR and AW
- axsize  out  3  `{1'b0,size}`; fetch is always 3'b010
- arvalid / arready  out / in  1  read-address handshake
- rdata  in  32  read data beat (single beat, `rlast` ignored)
- rvalid / rready  in / out  1  read-data handshake
- awvalid / awready  out / in  1  write-address handshake
- wdata  out  32  latched store data
- wstrb  out  4  byte strobes
- wvalid / wready  out / in  1  write-data handshake
- bvalid / bready  in / out  1  write-response handshake

## Operation
- FSM states: IDLE, AR, R, AW, B.
- IDLE: requests are granted here only.
  - Default priority is fixed: data over instruction.
  - The granted `*_addr_ok` is asserted in the same cycle as the request.
  - On grant, latch owner, address, size, `wr` and `wdata`.
  - Next state is AW if the request is a store, otherwise AR.
- AR: `arvalid`=1 until `arready`, then go to R.
- R: `rready`=1. On `rvalid`, latch `rdata` into the owner's rdata register and go to IDLE. The owner's `*_data_ok` pulses in the following cycle.
- AW: `awvalid` and `wvalid` are raised together. Each drops independently after its own handshake. Go to B once both have completed; both may complete in the same cycle.
- B: `bready`=1. On `bvalid`, go to IDLE, and `data_data_ok` pulses in the following cycle.
- wstrb:
  - size 0: `4'b0001 << addr[1:0]`
  - size 1: `4'b0011 << {addr[1],1'b0}`
  - size 2/3: `4'b1111`
- `inst_rdata` and `data_rdata` hold their last value until overwritten.

## Timing
- Reset values:
  - state = IDLE
  - all `*valid`, `rready`, `bready`, `*_addr_ok` and `*_data_ok` = 0
  - `axaddr`, `axsize`, `wdata`, `wstrb`, `inst_rdata` and `data_rdata` = 0
- Best-case load or fetch, 3 cycles: request/`addr_ok` in cycle 0; `arvalid` in cycle 1 (`arready` in cycle 1); `rvalid` in cycle 2; `data_ok` in cycle 3.
- Best-case store, 3 cycles: request in cycle 0; aw/w in cycle 1; `bvalid` in cycle 2; `data_ok` in cycle 3.
- The `data_ok` cycle is an IDLE cycle, so a new request may be accepted in that same cycle.
- Simultaneous `inst_req` and `data_req` in IDLE: only one `addr_ok` is issued; the loser stays pending.
- `rst` mid-transaction:
  - Next cycle is IDLE with all valids low and no `data_ok` pulse.
  - The AXI slave shares `rst`, so the abandoned transaction is discarded.
- `arvalid`, `awvalid` and `wvalid` never drop before their handshake, and `axaddr` is stable while any of them is high.

## Configuration
- `ARB_ROUND_ROBIN_EN`
  - Defined: when both request in IDLE, grant the requester that was not granted last. A one-bit last-grant register resets to "inst", so data wins first after reset.
  - Undefined: fixed data-over-instruction priority, and no last-grant register exists.

## Structure
- The shared cpu_axi package holds:
  - state encoding typedef
  - owner encoding (`OWN_INST`, `OWN_DATA`)
  - `SIZE_BYTE`/`SIZE_HALF`/`SIZE_WORD` constants
- One sub-module, `axi_wstrb_gen` (size + `addr[1:0]` -> wstrb), which is combinational and reused by the uncached store path.

## Test plan
- Lone fetch from 0xBFC00000, slave `arready`=1 and `rvalid` next cycle with 0x3C080001 -> `inst_data_ok` in cycle 3, `inst_rdata`=0x3C080001, `arid` path untouched.
- `inst_req` and `data_req` (load 0x80000010) both high in the same cycle -> only `data_addr_ok`; fetch granted in the `data_data_ok` cycle. With `ARB_ROUND_ROBIN_EN`, the second conflict is granted to inst.
- Byte store 0xAB to addr 0x80000003 -> `wstrb`=4'b1000, `axsize`=3'b000. Half store to 0x80000002 -> `wstrb`=4'b1100.
- Store where `wready` arrives 3 cycles after `awready` -> `awvalid` drops after its handshake, `wvalid` holds, B is entered only after `wready`, and `data_data_ok` pulses once.
- `rst` asserted while in R with `rvalid` low -> next cycle state IDLE, all valids 0, no `inst_data_ok` or `data_data_ok` pulse.

Source files
------------

// File: rtl/cpu_axi_arbiter_pkg.sv
// cpu_axi_arbiter_pkg
//   Shared definitions for the CPU-side AXI arbiter/bridge:
//     arb_state_t  - arbiter FSM state encoding
//     owner_t      - which requester owns the in-flight transaction
//     SIZE_*       - data_size encodings
//     norm_size()  - folds the reserved size code 3 onto a word access
package cpu_axi_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW   = 3'd3,
      ST_B    = 3'd4
   } arb_state_t;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // Size code 3 is not a legal request size; it is handled as a word.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == 2'd3) ? SIZE_WORD : size;
   endfunction

endpackage

// File: rtl/cpu_axi_arbiter_wstrb_gen.sv
// axi_wstrb_gen
//   Combinational AXI write-strobe generator for 32-bit lanes.
//   Ports:
//     size    in  2  access size (SIZE_BYTE / SIZE_HALF / SIZE_WORD, 3 = word)
//     addr_lo in  2  byte address bits [1:0]
//     wstrb   out 4  byte-lane strobes
module axi_wstrb_gen
   import cpu_axi_arbiter_pkg::*;
(
   input  logic [1:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] wstrb
);

   always_comb begin
      wstrb = 4'b1111;
      case (size)
         SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
         // Halfwords sit on lane pair 0-1 or 2-3; addr_lo[0] is ignored.
         SIZE_HALF: wstrb = 4'b0011 << {addr_lo[1], 1'b0};
         default:   wstrb = 4'b1111;
      endcase
   end

endmodule

// File: rtl/cpu_axi_arbiter.sv
// cpu_axi_arbiter
//   Single-outstanding arbiter/bridge: the instruction-fetch and data
//   SRAM-like request ports share one AXI master port, and exactly one AXI
//   transaction is in flight at a time.
//   Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants between
//   the two requesters on conflict; otherwise data always beats fetch.
//   Ports:
//     clk, rst                          clock, synchronous active-high reset
//     inst_req/addr, inst_addr_ok       fetch request / accept (comb, IDLE)
//     inst_rdata, inst_data_ok          fetch data / one-cycle completion
//     data_req/wr/size/addr/wdata       load/store request
//     data_addr_ok                      data accept (comb, IDLE)
//     data_rdata, data_data_ok          load data / one-cycle completion
//     axaddr, axsize                    latched address/size for AR and AW
//     arvalid/arready, rdata/rvalid/rready
//     awvalid/awready, wdata/wstrb/wvalid/wready, bvalid/bready
//   Handshakes: a channel transfers on a rising edge where its valid and
//   ready are both high; a valid raised by this block stays high, with its
//   payload stable, until that transfer happens.
module cpu_axi_arbiter
   import cpu_axi_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic [31:0] inst_rdata,
   output logic        inst_data_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic [31:0] data_rdata,
   output logic        data_data_ok,
   output logic [31:0] axaddr,
   output logic [2:0]  axsize,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   arb_state_t state;
   owner_t     owner;
   logic [1:0] req_size;
   logic [3:0] store_strb;
   logic       prefer_inst;
   logic       grant_data;
   logic       grant_inst;

   assign req_size = norm_size(data_size);

   axi_wstrb_gen u_wstrb (
      .size    (req_size),
      .addr_lo (data_addr[1:0]),
      .wstrb   (store_strb)
   );

`ifdef ARB_ROUND_ROBIN_EN
   // Last winner; after reset it reads "inst" so data wins the first tie.
   owner_t last_grant;

   always_ff @(posedge clk) begin
      if (rst)             last_grant <= OWN_INST;
      else if (grant_data) last_grant <= OWN_DATA;
      else if (grant_inst) last_grant <= OWN_INST;
   end

   assign prefer_inst = (last_grant == OWN_DATA);
`else
   assign prefer_inst = 1'b0;
`endif

   // Grants only happen in IDLE; a losing requester simply keeps req high.
   assign grant_data   = (state == ST_IDLE) && data_req && !(inst_req && prefer_inst);
   assign grant_inst   = (state == ST_IDLE) && inst_req && !grant_data;
   assign data_addr_ok = grant_data;
   assign inst_addr_ok = grant_inst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         owner        <= OWN_INST;
         axaddr       <= '0;
         axsize       <= '0;
         wdata        <= '0;
         wstrb        <= '0;
         arvalid      <= 1'b0;
         rready       <= 1'b0;
         awvalid      <= 1'b0;
         wvalid       <= 1'b0;
         bready       <= 1'b0;
         inst_rdata   <= '0;
         data_rdata   <= '0;
         inst_data_ok <= 1'b0;
         data_data_ok <= 1'b0;
      end else begin
         inst_data_ok <= 1'b0;
         data_data_ok <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_data) begin
                  owner  <= OWN_DATA;
                  axaddr <= data_addr;
                  axsize <= {1'b0, req_size};
                  if (data_wr) begin
                     wdata   <= data_wdata;
                     wstrb   <= store_strb;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     state   <= ST_AW;
                  end else begin
                     arvalid <= 1'b1;
                     state   <= ST_AR;
                  end
               end else if (grant_inst) begin
                  owner   <= OWN_INST;
                  axaddr  <= inst_addr;
                  axsize  <= {1'b0, SIZE_WORD};
                  arvalid <= 1'b1;
                  state   <= ST_AR;
               end
            end
            ST_AR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= ST_R;
               end
            end
            ST_R: begin
               if (rvalid) begin
                  rready <= 1'b0;
                  if (owner == OWN_INST) begin
                     inst_rdata   <= rdata;
                     inst_data_ok <= 1'b1;
                  end else begin
                     data_rdata   <= rdata;
                     data_data_ok <= 1'b1;
                  end
                  state <= ST_IDLE;
               end
            end
            ST_AW: begin
               if (awready) awvalid <= 1'b0;
               if (wready)  wvalid  <= 1'b0;
               // Each channel is finished once its valid is already low or
               // is being accepted this edge; both may finish together.
               if ((!awvalid || awready) && (!wvalid || wready)) begin
                  bready <= 1'b1;
                  state  <= ST_B;
               end
            end
            ST_B: begin
               if (bvalid) begin
                  bready       <= 1'b0;
                  data_data_ok <= 1'b1;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// tb_cpu_axi_arbiter
//   Bench for cpu_axi_arbiter: directed scenarios with literal expectations,
//   then randomized requesters against a randomized AXI slave, all watched
//   by a transaction-level reference model.
module tb_cpu_axi_arbiter;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        inst_req = 0, data_req = 0, data_wr = 0;
   logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0;
   logic [1:0]  data_size = 0;
   logic        arready = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
   logic [31:0] rdata = 0;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata, axaddr, wdata;
   logic [2:0]  axsize;
   logic [3:0]  wstrb;
   logic        arvalid, rready, awvalid, wvalid, bready;

   cpu_axi_arbiter dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_rdata(data_rdata), .data_data_ok(data_data_ok),
      .axaddr(axaddr), .axsize(axsize),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   // ---------------- counters / compare helpers ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   // ---------------- AXI slave driver ----------------
   int          p_ready = 100;   // percent chance of each *ready per cycle
   int          p_resp  = 100;   // percent chance of raising rvalid/bvalid
   bit          hold_w  = 0;
   bit          fixed_r_en = 0;
   logic [31:0] fixed_r = 0;
   bit          s_r_owed = 0, s_aw = 0, s_w = 0;

   // Records transfers at the clock edge (sees pre-edge DUT values).
   always @(posedge clk) begin
      if (rst) begin
         s_r_owed = 0; s_aw = 0; s_w = 0;
      end else begin
         if (rvalid && rready) s_r_owed = 0;
         if (arvalid && arready) s_r_owed = 1;
         if (bvalid && bready) begin s_aw = 0; s_w = 0; end
         if (awvalid && awready) s_aw = 1;
         if (wvalid && wready) s_w = 1;
      end
   end

   initial forever begin
      @(negedge clk);
      arready = ($urandom_range(99) < p_ready);
      awready = ($urandom_range(99) < p_ready);
      wready  = hold_w ? 1'b0 : ($urandom_range(99) < p_ready);
      if (!s_r_owed) rvalid = 1'b0;
      else if (!rvalid && ($urandom_range(99) < p_resp)) begin
         rvalid = 1'b1;
         rdata  = fixed_r_en ? fixed_r : $urandom();
      end
      if (!(s_aw && s_w)) bvalid = 1'b0;
      else if (!bvalid && ($urandom_range(99) < p_resp)) bvalid = 1'b1;
   end

   // ---------------- reference model / scoreboard ----------------
   // Entry: {owner_is_data, is_write, addr[31:0], axsize[2:0], wstrb[3:0], wdata[31:0]}
   logic [72:0] exp_q[$];
   bit          ar_d = 0, aw_d = 0, w_d = 0;
   bit          ok_i = 0, ok_d = 0, last_data = 0;
   logic [31:0] m_ird = 0, m_drd = 0;

   // Strobe = lanes covered by an n-byte access aligned down to n.
   function automatic logic [3:0] exp_wstrb(input logic [1:0] sz, input logic [31:0] addr);
      int n, lo;
      logic [3:0] s;
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      lo = (int'(addr[1:0]) / n) * n;
      s  = '0;
      for (int i = 0; i < 4; i++) s[i] = (i >= lo) && (i < lo + n);
      return s;
   endfunction

   initial begin : model
      logic        busy, g_d, g_i, t_own, t_wr;
      logic        e_ar, e_r, e_aw, e_w, e_b;
      logic [72:0] t;
      logic [2:0]  sz3;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            exp_q.delete();
            ar_d = 0; aw_d = 0; w_d = 0; ok_i = 0; ok_d = 0; last_data = 0;
            m_ird = '0; m_drd = '0;
         end else begin
            chk1("m_inst_data_ok", inst_data_ok, ok_i);
            chk1("m_data_data_ok", data_data_ok, ok_d);
            chk("m_inst_rdata", inst_rdata, m_ird);
            chk("m_data_rdata", data_rdata, m_drd);
            ok_i = 0; ok_d = 0;

            busy = (exp_q.size() != 0);
            g_d  = !busy && data_req && !(inst_req && RR && last_data);
            g_i  = !busy && inst_req && !g_d;
            chk1("m_data_addr_ok", data_addr_ok, g_d);
            chk1("m_inst_addr_ok", inst_addr_ok, g_i);

            t     = busy ? exp_q[0] : '0;
            t_own = t[72];
            t_wr  = t[71];
            e_ar  = busy && !t_wr && !ar_d;
            e_r   = busy && !t_wr && ar_d;
            e_aw  = busy && t_wr && !aw_d;
            e_w   = busy && t_wr && !w_d;
            e_b   = busy && t_wr && aw_d && w_d;
            chk1("m_arvalid", arvalid, e_ar);
            chk1("m_rready", rready, e_r);
            chk1("m_awvalid", awvalid, e_aw);
            chk1("m_wvalid", wvalid, e_w);
            chk1("m_bready", bready, e_b);
            if (e_ar || e_aw) begin
               chk("m_axaddr", axaddr, t[70:39]);
               chk("m_axsize", 32'(axsize), 32'(t[38:36]));
            end
            if (e_w) begin
               chk("m_wdata", wdata, t[31:0]);
               chk("m_wstrb", 32'(wstrb), 32'(t[35:32]));
            end

            if (e_ar && arready) ar_d = 1;
            if (e_aw && awready) aw_d = 1;
            if (e_w && wready) w_d = 1;
            if (e_r && rvalid) begin
               if (t_own) begin m_drd = rdata; ok_d = 1; end
               else       begin m_ird = rdata; ok_i = 1; end
               void'(exp_q.pop_front());
            end
            if (e_b && bvalid) begin
               ok_d = 1;
               void'(exp_q.pop_front());
            end

            if (g_d) begin
               sz3 = {1'b0, (data_size == 2'd3) ? 2'd2 : data_size};
               exp_q.push_back({1'b1, data_wr, data_addr, sz3,
                                data_wr ? exp_wstrb(data_size, data_addr) : 4'b0000,
                                data_wr ? data_wdata : 32'h0});
            end else if (g_i) begin
               exp_q.push_back({1'b0, 1'b0, inst_addr, 3'b010, 4'b0000, 32'h0});
            end
            if (g_d || g_i) begin
               ar_d = 0; aw_d = 0; w_d = 0;
               last_data = g_d;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(negedge clk);
   endtask

   function automatic logic sig_val(input int s);
      case (s)
         0: return inst_addr_ok;
         1: return data_addr_ok;
         2: return inst_data_ok;
         default: return data_data_ok;
      endcase
   endfunction

   // Called at negedge+1; advances whole cycles until the signal is seen.
   task automatic wait_for(input int s, input string name);
      int k;
      k = 0;
      while (!sig_val(s) && k < 64) begin
         next_cycle();
         #1;
         k++;
      end
      chk1(name, sig_val(s), 1'b1);
   endtask

   task automatic data_request(input logic wr, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] wd);
      data_req = 1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
   endtask

   // ---------------- main stimulus ----------------
   bit w_inst, i_acc, d_acc;

   initial begin
      repeat (3) next_cycle();
      rst = 0;
      #1;
      chk1("reset_arvalid", arvalid, 0);
      chk1("reset_awvalid", awvalid, 0);
      chk1("reset_wvalid", wvalid, 0);
      chk1("reset_rready", rready, 0);
      chk1("reset_bready", bready, 0);
      chk("reset_axaddr", axaddr, 32'h0);
      chk("reset_wstrb", 32'(wstrb), 32'h0);
      chk("reset_inst_rdata", inst_rdata, 32'h0);

      // Lone fetch, fastest slave: data_ok in cycle 3.
      fixed_r_en = 1; fixed_r = 32'h3C080001;
      next_cycle(); inst_req = 1; inst_addr = 32'hBFC00000; #1;
      chk1("fetch_addr_ok", inst_addr_ok, 1);
      chk1("fetch_no_data_ok", data_addr_ok, 0);
      next_cycle(); inst_req = 0; #1;
      chk1("fetch_arvalid_c1", arvalid, 1);
      chk("fetch_axaddr", axaddr, 32'hBFC00000);
      chk("fetch_axsize", 32'(axsize), 32'd2);
      next_cycle(); #1;
      chk1("fetch_rready_c2", rready, 1);
      chk1("fetch_no_ok_c2", inst_data_ok, 0);
      next_cycle(); #1;
      chk1("fetch_data_ok_c3", inst_data_ok, 1);
      chk("fetch_rdata", inst_rdata, 32'h3C080001);
      next_cycle(); #1;
      chk1("fetch_ok_pulse", inst_data_ok, 0);
      fixed_r_en = 0;

      // Conflict: data wins, fetch granted in the data_data_ok cycle.
      next_cycle();
      inst_req = 1; inst_addr = 32'h80001000;
      data_request(0, 2'd2, 32'h80000010, 32'h0);
      #1;
      chk1("conflict_data_ok", data_addr_ok, 1);
      chk1("conflict_inst_wait", inst_addr_ok, 0);
      next_cycle(); data_req = 0; #1;
      chk1("conflict_busy", inst_addr_ok, 0);
      wait_for(3, "conflict_load_done");
      chk1("conflict_inst_in_ok_cycle", inst_addr_ok, 1);
      next_cycle(); inst_req = 0; #1;
      wait_for(2, "conflict_fetch_done");

      // Lone load, then a second conflict (last winner = data).
      next_cycle(); data_request(0, 2'd2, 32'h80000020, 32'h0); #1;
      chk1("lone_load_ok", data_addr_ok, 1);
      next_cycle(); data_req = 0; #1;
      wait_for(3, "lone_load_done");
      next_cycle();
      inst_req = 1; inst_addr = 32'h80002000;
      data_request(0, 2'd2, 32'h80000030, 32'h0);
      #1;
`ifdef ARB_ROUND_ROBIN_EN
      chk1("conflict2_inst_wins", inst_addr_ok, 1);
      chk1("conflict2_data_loses", data_addr_ok, 0);
`else
      chk1("conflict2_data_wins", data_addr_ok, 1);
      chk1("conflict2_inst_loses", inst_addr_ok, 0);
`endif
      w_inst = inst_addr_ok;
      next_cycle();
      if (w_inst) inst_req = 0; else data_req = 0;
      #1;
      wait_for(w_inst ? 1 : 0, "conflict2_loser_grant");
      next_cycle(); inst_req = 0; data_req = 0; #1;
      wait_for(w_inst ? 3 : 2, "conflict2_loser_done");

      // Byte and half stores.
      next_cycle(); data_request(1, 2'd0, 32'h80000003, 32'hAB000000); #1;
      chk1("sb_addr_ok", data_addr_ok, 1);
      next_cycle(); data_req = 0; #1;
      chk1("sb_awvalid", awvalid, 1);
      chk1("sb_wvalid", wvalid, 1);
      chk("sb_wstrb", 32'(wstrb), 32'b1000);
      chk("sb_axsize", 32'(axsize), 32'd0);
      chk("sb_wdata", wdata, 32'hAB000000);
      wait_for(3, "sb_done");
      next_cycle(); data_request(1, 2'd1, 32'h80000002, 32'hCDEF0000); #1;
      next_cycle(); data_req = 0; #1;
      chk("sh_wstrb", 32'(wstrb), 32'b1100);
      chk("sh_axsize", 32'(axsize), 32'd1);
      wait_for(3, "sh_done");

      // Store with wready three cycles after awready.
      hold_w = 1;
      next_cycle(); data_request(1, 2'd2, 32'h80000040, 32'h12345678); #1;
      next_cycle(); data_req = 0; #1;
      chk1("dw_awvalid_c1", awvalid, 1);
      chk1("dw_wvalid_c1", wvalid, 1);
      for (int i = 0; i < 3; i++) begin
         next_cycle(); #1;
         chk1("dw_awvalid_dropped", awvalid, 0);
         chk1("dw_wvalid_held", wvalid, 1);
         chk1("dw_no_b_yet", bready, 0);
         if (i == 1) hold_w = 0;
      end
      next_cycle(); #1;
      chk1("dw_bready", bready, 1);
      chk1("dw_wvalid_low", wvalid, 0);
      chk1("dw_no_ok_yet", data_data_ok, 0);
      next_cycle(); #1;
      chk1("dw_data_ok", data_data_ok, 1);
      next_cycle(); #1;
      chk1("dw_data_ok_once", data_data_ok, 0);

      // Reset while waiting in R.
      p_resp = 0;
      next_cycle(); data_request(0, 2'd2, 32'h80000050, 32'h0); #1;
      next_cycle(); data_req = 0; #1;
      chk1("rst_arvalid", arvalid, 1);
      next_cycle(); #1;
      chk1("rst_in_r", rready, 1);
      next_cycle(); rst = 1; #1;
      next_cycle(); rst = 0; #1;
      chk1("rst_rready", rready, 0);
      chk1("rst_arvalid_low", arvalid, 0);
      chk1("rst_awvalid_low", awvalid, 0);
      chk1("rst_wvalid_low", wvalid, 0);
      chk1("rst_no_data_ok", data_data_ok, 0);
      chk1("rst_no_inst_ok", inst_data_ok, 0);
      chk("rst_data_rdata", data_rdata, 32'h0);
      next_cycle(); #1;
      chk1("rst_no_data_ok_later", data_data_ok, 0);

      // Randomized traffic against a random slave.
      p_ready = 60; p_resp = 50;
      i_acc = 0; d_acc = 0;
      for (int c = 0; c < 4000; c++) begin
         next_cycle();
         if (c == 2000) begin rst = 1; inst_req = 0; data_req = 0; end
         else if (c == 2002) rst = 0;
         if (!rst) begin
            if (!inst_req || i_acc) begin
               inst_req  = ($urandom_range(2) == 0);
               inst_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!data_req || d_acc) begin
               data_req   = ($urandom_range(2) == 0);
               data_wr    = 1'($urandom_range(1));
               data_size  = 2'($urandom_range(3));
               data_addr  = $urandom();
               data_wdata = $urandom();
            end
         end
         #1;
         i_acc = !rst && inst_req && inst_addr_ok;
         d_acc = !rst && data_req && data_addr_ok;
      end
      next_cycle(); inst_req = 0; data_req = 0;
      repeat (60) next_cycle();
      chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      n_bad++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

endmodule
